// File: rtl/core_sequencer.sv
// core_sequencer
//   Multi-cycle control sequencer for the RV32I core. Owns the PC and the
//   instruction register and steps each instruction through FETCH, DECODE,
//   EXECUTE, optional MEM and WB, handshaking with instruction and data
//   memories and issuing the register-file write strobe.
//
// Ports
//   clk, rst_n            clock; synchronous active-low reset
//   imem_req/addr/ack/rdata  instruction fetch handshake (addr == pc)
//   inst                  instruction register, drives the decoder
//   dec_*                 decoded class flags for inst
//   alu_out               ALU result / JAL(R) target
//   br_taken, br_target   branch decision and target
//   dmem_req/we/ack       data access handshake (we: 1 = store)
//   rf_we                 register-file write strobe (one cycle)
//   pc                    current instruction PC
//   retire                one pulse per completed instruction
//   trap, trap_pc         trap pulse and faulting PC
//
// Build option
//   CORE_SEQ_TRAP_EN: builds the TRAP state. Illegal instructions and
//   misaligned jump/taken-branch targets go to TRAP_VEC. When undefined,
//   trap/trap_pc are tied to 0, illegal instructions retire as NOPs and
//   target bits [1:0] are forced to 0.
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  input  logic        dec_load,
  input  logic        dec_store,
  input  logic        dec_rf_wen,
  input  logic        dec_jump,
  input  logic        dec_branch,
  input  logic        dec_illegal,
  input  logic [31:0] alu_out,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic        retire,
  output logic        trap,
  output logic [31:0] trap_pc
);

  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef CORE_SEQ_TRAP_EN
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, TRAP} state_t;
`else
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB} state_t;
`endif

  state_t      state, state_nxt;
  logic        commit;
  logic        imem_req_c, dmem_req_c, dmem_we_c, rf_we_c;
  logic [31:0] pc_commit;

  // Only bits [31:2] of the targets feed the PC; the low bits matter only
  // for the misalignment trap.
  logic unused_bits;
  assign unused_bits = ^{alu_out[1:0], br_target[1:0], TRAP_VEC};

`ifdef CORE_SEQ_TRAP_EN
  logic trap_c;
  logic misaligned;
  // JAL/JALR target is {alu_out[31:1],0}, so only alu_out[1] can misalign it.
  assign misaligned = (dec_jump && alu_out[1]) ||
                      (dec_branch && br_taken && (br_target[1:0] != 2'b00));
`endif

  always_comb begin
    if (dec_illegal)
      pc_commit = pc + 32'd4;
    else if (dec_jump)
      pc_commit = {alu_out[31:2], 2'b00};
    else if (dec_branch && br_taken)
      pc_commit = {br_target[31:2], 2'b00};
    else
      pc_commit = pc + 32'd4;
  end

  always_comb begin
    state_nxt  = state;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    rf_we_c    = 1'b0;
    commit     = 1'b0;
`ifdef CORE_SEQ_TRAP_EN
    trap_c     = 1'b0;
`endif
    case (state)
      FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ack)
          state_nxt = DECODE;
      end
      DECODE: state_nxt = EXECUTE;
      EXECUTE: begin
`ifdef CORE_SEQ_TRAP_EN
        if (dec_illegal || misaligned)
          state_nxt = TRAP;
`else
        if (dec_illegal)
          state_nxt = WB;
`endif
        else if (dec_load || dec_store)
          state_nxt = MEM;
        else
          state_nxt = WB;
      end
      MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = dec_store;
        if (dmem_ack) begin
          if (dec_store) begin
            commit    = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = WB;
          end
        end
      end
      WB: begin
        rf_we_c   = dec_rf_wen & ~dec_illegal;
        commit    = 1'b1;
        state_nxt = FETCH;
      end
`ifdef CORE_SEQ_TRAP_EN
      TRAP: begin
        trap_c    = 1'b1;
        state_nxt = FETCH;
      end
`endif
      default: state_nxt = FETCH;
    endcase
  end

  // Strobes are forced low while reset is asserted, whatever the state.
  assign imem_req  = imem_req_c & rst_n;
  assign dmem_req  = dmem_req_c & rst_n;
  assign dmem_we   = dmem_we_c & rst_n;
  assign rf_we     = rf_we_c & rst_n;
  assign retire    = commit & rst_n;
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
      pc    <= RESET_PC;
      inst  <= NOP;
    end else begin
      state <= state_nxt;
      if (state == FETCH && imem_ack)
        inst <= imem_rdata;
      if (commit)
        pc <= pc_commit;
`ifdef CORE_SEQ_TRAP_EN
      if (state == TRAP)
        pc <= TRAP_VEC;
`endif
    end
  end

`ifdef CORE_SEQ_TRAP_EN
  assign trap = trap_c & rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n)
      trap_pc <= '0;
    else if (state == TRAP)
      trap_pc <= pc;
  end
`else
  assign trap    = 1'b0;
  assign trap_pc = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
module tb_core_sequencer;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] TVEC    = 32'h0000_0100;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  localparam int K_ALU   = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;
  localparam int K_BR    = 3;
  localparam int K_JUMP  = 4;
  localparam int K_ILL   = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst;
  logic        dec_load = 1'b0, dec_store = 1'b0, dec_rf_wen = 1'b0;
  logic        dec_jump = 1'b0, dec_branch = 1'b0, dec_illegal = 1'b0;
  logic [31:0] alu_out = '0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        dmem_req, dmem_we;
  logic        dmem_ack = 1'b0;
  logic        rf_we;
  logic [31:0] pc;
  logic        retire, trap;
  logic [31:0] trap_pc;

  int n_cmp = 0;
  int n_bad = 0;

  // Architectural model state: the PC and trap PC the next instruction should see.
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_trap_pc = '0;

  core_sequencer #(.RESET_PC(RST_PC), .TRAP_VEC(TVEC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst(inst),
    .dec_load(dec_load), .dec_store(dec_store), .dec_rf_wen(dec_rf_wen),
    .dec_jump(dec_jump), .dec_branch(dec_branch), .dec_illegal(dec_illegal),
    .alu_out(alu_out), .br_taken(br_taken), .br_target(br_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .pc(pc), .retire(retire), .trap(trap), .trap_pc(trap_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  // Runs one instruction from its first FETCH cycle to its retire/trap cycle
  // and compares the observed behaviour with the instruction-level model.
  task automatic run_insn(input int kind, input int iw, input int dw, input logic [31:0] word,
                          input logic [31:0] aluv, input logic tk, input logic [31:0] btgt,
                          input bit stray);
    int cyc, ireq, dreq, nrf, nret, ntrap, addr_bad, we_bad;
    int exp_cyc, exp_rf, exp_dreq;
    bit done, exp_trap, is_mem, exp_we;
    logic [31:0] exp_next;
    logic [31:0] inst_seen;
    cyc = 0; ireq = 0; dreq = 0; nrf = 0; nret = 0; ntrap = 0; addr_bad = 0; we_bad = 0;
    done = 0; inst_seen = '0;

    exp_trap = 0;
`ifdef CORE_SEQ_TRAP_EN
    exp_trap = (kind == K_ILL) || (kind == K_JUMP && aluv[1]) ||
               (kind == K_BR && tk && btgt[1:0] != 2'b00);
`endif
    is_mem   = !exp_trap && (kind == K_LOAD || kind == K_STORE);
    exp_we   = (kind == K_STORE);
    exp_cyc  = (iw + 1) + 2 + (is_mem ? (dw + 1) + ((kind == K_LOAD) ? 1 : 0) : 1);
    exp_dreq = is_mem ? dw + 1 : 0;
    exp_rf   = (!exp_trap && (kind == K_ALU || kind == K_LOAD || kind == K_JUMP)) ? 1 : 0;
    if (exp_trap)                   exp_next = TVEC;
    else if (kind == K_JUMP)        exp_next = aluv & ~32'd3;
    else if (kind == K_BR && tk)    exp_next = btgt & ~32'd3;
    else                            exp_next = m_pc + 32'd4;

    while (!done && cyc < 64) begin
      @(negedge clk);
      #1;
      if (cyc == 0) begin
        dec_load    = (kind == K_LOAD) || (kind == K_ILL);
        dec_store   = (kind == K_STORE);
        dec_rf_wen  = (kind == K_ALU) || (kind == K_LOAD) || (kind == K_JUMP) || (kind == K_ILL);
        dec_jump    = (kind == K_JUMP);
        dec_branch  = (kind == K_BR);
        dec_illegal = (kind == K_ILL);
        alu_out     = aluv;
        br_taken    = tk;
        br_target   = btgt;
        n_cmp++;
        if (pc !== m_pc) begin
          n_bad++;
          $display("FAIL pc_at_fetch: got %h, expected %h", pc, m_pc);
        end
        n_cmp++;
        if (trap_pc !== m_trap_pc) begin
          n_bad++;
          $display("FAIL trap_pc: got %h, expected %h", trap_pc, m_trap_pc);
        end
      end
      cyc++;
      if (imem_req) begin
        if (imem_addr !== m_pc) addr_bad++;
        imem_ack   = (ireq == iw);
        imem_rdata = (ireq == iw) ? word : $urandom;
        ireq++;
      end else begin
        imem_ack   = stray ? 1'($urandom_range(0, 1)) : 1'b0;
        imem_rdata = $urandom;
      end
      if (dmem_req) begin
        if (dmem_we !== exp_we) we_bad++;
        dmem_ack = (dreq == dw);
        dreq++;
      end else begin
        dmem_ack = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      #1;
      if (rf_we)  nrf++;
      if (retire) nret++;
      if (trap)   ntrap++;
      if (retire || trap) begin
        done = 1;
        inst_seen = inst;
      end
    end

    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL insn_timeout: kind %0d got no retire/trap in %0d cycles, required one", kind, cyc);
    end
    n_cmp++;
    if (cyc != exp_cyc) begin
      n_bad++;
      $display("FAIL cycles: kind %0d iw %0d dw %0d got %0d, expected %0d", kind, iw, dw, cyc, exp_cyc);
    end
    n_cmp++;
    if (ireq != iw + 1 || addr_bad != 0) begin
      n_bad++;
      $display("FAIL imem_req: got %0d req cycles (%0d bad addr), expected %0d at %h", ireq, addr_bad, iw + 1, m_pc);
    end
    n_cmp++;
    if (dreq != exp_dreq || we_bad != 0) begin
      n_bad++;
      $display("FAIL dmem_req: got %0d req cycles (%0d bad we), expected %0d", dreq, we_bad, exp_dreq);
    end
    n_cmp++;
    if (nrf != exp_rf) begin
      n_bad++;
      $display("FAIL rf_we: kind %0d got %0d pulses, expected %0d", kind, nrf, exp_rf);
    end
    n_cmp++;
    if (nret != (exp_trap ? 0 : 1) || ntrap != (exp_trap ? 1 : 0)) begin
      n_bad++;
      $display("FAIL retire_trap: got retire %0d trap %0d, expected retire %0d trap %0d",
               nret, ntrap, exp_trap ? 0 : 1, exp_trap ? 1 : 0);
    end
    n_cmp++;
    if (inst_seen !== word) begin
      n_bad++;
      $display("FAIL inst: got %h, expected %h", inst_seen, word);
    end

    if (exp_trap) m_trap_pc = m_pc;
    m_pc = exp_next;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if ({imem_req, dmem_req, rf_we, retire, trap} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_strobes: got %b, expected 00000", {imem_req, dmem_req, rf_we, retire, trap});
    end
    n_cmp++;
    if (pc !== RST_PC || inst !== NOP || trap_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_regs: got pc %h inst %h trap_pc %h, expected %h %h 0", pc, inst, trap_pc, RST_PC, NOP);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_pc = RST_PC;
    m_trap_pc = '0;
  endtask

  task automatic test_directed();
    // ADDI at 0x0, zero-wait: 4 cycles, pc -> 0x4
    run_insn(K_ALU, 0, 0, 32'h0010_0093, 32'h1, 1'b0, 32'h0, 1'b0);
    // jump to 0x10, then a load with a 3-cycle dmem delay
    run_insn(K_JUMP, 1, 0, 32'h00c0_006f, 32'h10, 1'b0, 32'h0, 1'b0);
    run_insn(K_LOAD, 0, 3, 32'h0000_2083, 32'h100, 1'b0, 32'h0, 1'b0);
    // zero-wait store
    run_insn(K_STORE, 0, 0, 32'h0010_2023, 32'h200, 1'b0, 32'h0, 1'b0);
    // taken branch to 0x40, then JALR with alu_out 0x81 -> 0x80
    run_insn(K_BR, 0, 0, 32'h0000_0063, 32'h0, 1'b1, 32'h40, 1'b0);
    run_insn(K_JUMP, 0, 0, 32'h0000_80e7, 32'h81, 1'b0, 32'h0, 1'b0);
    // not-taken branch at 0xFFFF_FFFC wraps to 0
    run_insn(K_JUMP, 0, 0, 32'h0000_006f, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
    run_insn(K_BR, 2, 0, 32'h0000_1063, 32'h0, 1'b0, 32'h1234, 1'b0);
    // illegal instruction at 0x20
    run_insn(K_JUMP, 0, 0, 32'h0200_006f, 32'h20, 1'b0, 32'h0, 1'b0);
    run_insn(K_ILL, 0, 0, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      int kind;
      logic [31:0] aluv, btgt;
      kind = $urandom_range(0, 5);
      aluv = $urandom;
      btgt = $urandom;
      if ($urandom_range(0, 3) != 0) aluv = aluv & ~32'd3;
      if ($urandom_range(0, 3) != 0) btgt = btgt & ~32'd3;
      run_insn(kind, $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
               aluv, 1'($urandom_range(0, 1)), btgt, 1'b1);
    end
  endtask

  task automatic test_reset_mid_mem();
    bit seen;
    int guard;
    seen = 0;
    guard = 0;
    while (!seen && guard < 32) begin
      @(negedge clk);
      #1;
      if (guard == 0) begin
        dec_load = 1'b1; dec_store = 1'b0; dec_rf_wen = 1'b1;
        dec_jump = 1'b0; dec_branch = 1'b0; dec_illegal = 1'b0;
      end
      guard++;
      imem_ack = imem_req;
      dmem_ack = 1'b0;
      if (dmem_req) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL mid_mem_reach: got no dmem_req in %0d cycles, required one", guard);
    end
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (dmem_req !== 1'b0 || imem_req !== 1'b0 || retire !== 1'b0 || rf_we !== 1'b0 || pc !== RST_PC) begin
      n_bad++;
      $display("FAIL mid_mem_reset: got dmem_req %b imem_req %b retire %b rf_we %b pc %h, expected 0 0 0 0 %h",
               dmem_req, imem_req, retire, rf_we, pc, RST_PC);
    end
    dmem_ack = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_pc = RST_PC;
    m_trap_pc = '0;
    // stray data acks during the following instructions must be ignored
    run_insn(K_ALU, 1, 0, 32'h0020_0113, 32'h5, 1'b0, 32'h0, 1'b1);
    run_insn(K_STORE, 0, 2, 32'h0020_2223, 32'h300, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
